// File: rtl/wb_stage_pipe.sv
// Write-back stage with MEM/WB pipeline register, variable-latency load wait,
// load alignment/extension, result select, upstream stall and retire counting.
module wb_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_MEM,
    input  logic                flush_MEMWB,
    input  logic [XLEN-1:0]     alu_result_MEM,
    input  logic [XLEN-1:0]     PC_plus4_MEM,
    input  logic [XLEN-1:0]     imm_MEM,
    input  logic [1:0]          mem2reg_MEM,
    input  logic                regWrite_MEM,
    input  logic [REG_AW-1:0]   rd_MEM,
    input  logic [2:0]          funct3_MEM,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                stall_WB,
    output logic                load_timeout,
    output logic [CNT_W-1:0]    retire_cnt
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("wb_stage_pipe: only XLEN=32 is supported");
    end
    if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
        $error("wb_stage_pipe: MAX_WAIT must be in 1..255");
    end

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Select the addressed byte/halfword and extend it according to funct3.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [XLEN-1:0] res_v;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'd0, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b101:  res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    logic              valid_r;
    logic [1:0]        sel_r;
    logic              we_r;
    logic [REG_AW-1:0] rd_r;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   alu_r;
    logic [XLEN-1:0]   pc4_r;
    logic [XLEN-1:0]   imm_r;
    state_t            state_r;
    logic [7:0]        wait_cnt_r;
    logic [CNT_W-1:0]  retire_cnt_r;

    logic              is_load_s;
    logic              timeout_now_s;
    logic              stall_s;
    logic              complete_s;
    logic              rf_we_s;
    logic [XLEN-1:0]   wdata_s;

    // Completion, stall and timeout decode for the instruction held in WB.
    always_comb begin
        is_load_s     = valid_r & (sel_r == 2'b01);
        timeout_now_s = is_load_s & ~dmem_rvalid & (state_r == ST_WAIT)
                        & (wait_cnt_r == MAX_WAIT_C);
        stall_s       = is_load_s & ~dmem_rvalid & ~timeout_now_s;
        complete_s    = valid_r & ~stall_s;
        rf_we_s       = complete_s & we_r & (rd_r != {REG_AW{1'b0}}) & ~timeout_now_s;
    end

    // Result source select.
    always_comb begin
        wdata_s = alu_r;
        case (sel_r)
            2'b00:   wdata_s = alu_r;
            2'b01:   wdata_s = load_extend(f3_r, alu_r[1:0], dmem_rdata);
            2'b10:   wdata_s = pc4_r;
            2'b11:   wdata_s = imm_r;
            default: wdata_s = alu_r;
        endcase
    end

    assign rf_we        = rf_we_s;
    assign rf_waddr     = rd_r;
    assign rf_wdata     = wdata_s;
    assign stall_WB     = stall_s;
    assign load_timeout = timeout_now_s;
    assign retire_cnt   = retire_cnt_r;

    // MEM/WB pipeline register; holds while stalled, so a flush is ignored then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            sel_r   <= 2'b00;
            we_r    <= 1'b0;
            rd_r    <= {REG_AW{1'b0}};
            f3_r    <= 3'b000;
            alu_r   <= {XLEN{1'b0}};
            pc4_r   <= {XLEN{1'b0}};
            imm_r   <= {XLEN{1'b0}};
        end else if (!stall_s) begin
            valid_r <= valid_MEM & ~flush_MEMWB;
            sel_r   <= mem2reg_MEM;
            we_r    <= regWrite_MEM;
            rd_r    <= rd_MEM;
            f3_r    <= funct3_MEM;
            alu_r   <= alu_result_MEM;
            pc4_r   <= PC_plus4_MEM;
            imm_r   <= imm_MEM;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Load-wait FSM with wait-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (is_load_s && !dmem_rvalid) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid || timeout_now_s || !is_load_s) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end else begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Retired-instruction counter; timeouts retire too, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (complete_s) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Next-generation write-back stage with its own MEM/WB pipeline register. It waits on a variable-latency data-memory read response and aligns and sign/zero-extends load data. It selects one of four result sources and drives the register-file write port. It also produces a stall to upstream stages, a load-timeout indication and a retired-instruction counter.

Parameters:
XLEN, 32, datapath width; only 32 is supported; elaboration error otherwise.
REG_AW, 5, register-address width.
MAX_WAIT, 15, maximum wait cycles for a load response before timeout (1..255).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active-low.
valid_MEM  in  1  instruction present in MEM stage.
flush_MEMWB  in  1  load a bubble into the MEM/WB register instead of MEM-stage contents.
alu_result_MEM  in  XLEN  ALU result / load address.
PC_plus4_MEM  in  XLEN  return address for JAL/JALR.
imm_MEM  in  XLEN  U-type immediate (LUI).
mem2reg_MEM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
regWrite_MEM  in  1  instruction writes rd.
rd_MEM  in  REG_AW  destination register.
funct3_MEM  in  3  load size/sign.
dmem_rvalid  in  1  load data valid this cycle.
dmem_rdata  in  XLEN  raw aligned word from data memory.
rf_we  out  1  register-file write enable.
rf_waddr  out  REG_AW  write address.
rf_wdata  out  XLEN  write data (also the forwarding source).
stall_WB  out  1  hold MEM and earlier stages.
load_timeout  out  1  one-cycle pulse when a load is abandoned.
retire_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (rst_n=0 at an edge):
  - valid_q=0; all pipeline fields 0; FSM=RUN; wait_cnt=0; retire_cnt=0.
  - Outputs in the following cycle: rf_we=0, rf_waddr=0, rf_wdata=0, stall_WB=0, load_timeout=0.
  - Reset mid-wait abandons the load with no write and no timeout pulse.
- MEM/WB register update:
  - When stall_WB=0: the register captures MEM-stage fields.
  - valid_q <= valid_MEM & ~flush_MEMWB. Flush wins over valid.
  - When stall_WB=1: the register holds, and flush is ignored.
- Load pending: is_load = valid_q & (sel_q==01).
- FSM states: RUN and WAIT.
  - RUN: if is_load and dmem_rvalid=0 -> go to WAIT, stall_WB=1, wait_cnt<=1. If is_load and dmem_rvalid=1 -> complete this cycle, stay in RUN. Non-load valid instructions complete in the cycle they occupy WB (latency 1 after MEM capture).
  - WAIT: stall_WB=1 while dmem_rvalid=0.
    - When dmem_rvalid=1: complete, stall_WB=0, go to RUN.
    - When wait_cnt==MAX_WAIT and still no rvalid: load_timeout=1, stall_WB=0, instruction retires without a write, go to RUN.
    - Otherwise wait_cnt increments.
  - dmem_rvalid arriving when is_load=0 is ignored.
- stall_WB is combinational: is_load & ~dmem_rvalid & ~timeout_now.
- Completion cycle:
  - rf_we = we_q & (rd_q!=0) & ~timeout.
  - rf_waddr = rd_q; rf_wdata is the selected source.
  - rf_we=0 whenever there is no completion.
  - retire_cnt increments by 1 on every completion, including timeouts. It wraps modulo 2^CNT_W.
- Result select: 00 alu_q, 01 extended load, 10 pc4_q, 11 imm_q.
- Load extension uses off = alu_q[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1], sign-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - 010 LW: whole word.
  - Other funct3 values are treated as LW.
  - Misaligned halfword (off[0]=1) uses off[1] only; no exception.
- rf_wdata when rf_we=0 is don't-care. The bench checks it only when rf_we=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with valid_MEM=1 -> rf_we=0, stall_WB=0, retire_cnt=0.
- ALU write, then PC+4, then LUI on consecutive cycles (sel=00/10/11, rd=5/6/7, values 0x11, 0x104, 0xABCDE000) -> rf_we=1 with matching addr/data one cycle after each MEM capture; retire_cnt=3.
- Load LB off=3, rdata=0x80FF_0000, rvalid delayed 3 cycles -> stall_WB=1 for 3 cycles, then rf_wdata=0xFFFFFF80; MEM stage held throughout. Repeat as LBU -> 0x00000080. LH off=2 -> 0xFFFF80FF.
- Load with rvalid never asserted, MAX_WAIT=15 -> stall for 15 cycles, load_timeout pulse, rf_we=0, retire_cnt+1, next instruction proceeds.
- rd=0 ALU write -> rf_we=0, retire_cnt increments. flush_MEMWB=1 with valid_MEM=1 -> no retire. Flush asserted during a stall -> ignored, held load still completes.
- rst_n=0 during WAIT -> stall_WB=0 next cycle, no write, load_timeout=0.
